// File: rtl/flash_sample_streamer.sv
// Flash-backed audio sample streamer: prefetches clip words over
// Avalon-MM and hands out one sample per consumer tick.
module flash_sample_streamer #(
   parameter int ADDR_W     = 23,
   parameter int DATA_W     = 32,
   parameter int SAMPLE_W   = 8,
   parameter int BASE       = 0,
   parameter int MAX_OFFSET = 16'h7FFF
) (
   input  logic                fetch_clock,
   input  logic                reset,
   input  logic                play,
   input  logic                reverse,
   input  logic                loop,
   input  logic                sample_tick,
   input  logic                flash_mem_waitrequest,
   input  logic [DATA_W-1:0]   flash_mem_readdata,
   input  logic                flash_mem_readdatavalid,
   output logic                flash_mem_read,
   output logic [ADDR_W-1:0]   flash_mem_address,
   output logic [SAMPLE_W-1:0] audio_out,
   output logic                audio_valid,
   output logic                done,
   output logic                underrun
);
   localparam int LANES  = DATA_W / SAMPLE_W;
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [ADDR_W-1:0] CLIP_FIRST = ADDR_W'(BASE);
   localparam logic [ADDR_W-1:0] CLIP_LAST  = ADDR_W'(BASE + MAX_OFFSET);
   localparam logic [LANE_W-1:0] LANE_TOP   = LANE_W'(LANES - 1);

   typedef enum logic {IDLE, RUN} play_state_t;
   typedef enum logic [1:0] {B_IDLE, B_REQ, B_WAIT} bus_state_t;

   play_state_t play_state, play_next;
   bus_state_t  bus_state, bus_next;

   logic              play_q, dir, stale, fetch_stop;
   logic [ADDR_W-1:0] fetch_addr;
   logic [DATA_W-1:0] cur_data, pre_data, lane_word;
   logic              cur_valid, pre_valid, cur_last, pre_last;
   logic [LANE_W-1:0] lane, lane_first;

   logic start, leave, issue, returned, load;
   logic consume, lane_end, finish, tick_miss, fetch_at_end;

   assign flash_mem_read = (bus_state == B_REQ);
   assign lane_word      = cur_data >> (int'(lane) * SAMPLE_W);
   assign lane_first     = dir ? LANE_TOP : '0;
   assign lane_end       = dir ? (lane == '0) : (lane == LANE_TOP);
   assign fetch_at_end   = dir ? (fetch_addr == CLIP_FIRST)
                               : (fetch_addr == CLIP_LAST);
   assign returned       = (bus_state == B_WAIT) && flash_mem_readdatavalid;

   always_comb begin
      play_next = play_state;
      bus_next  = bus_state;
      start     = 1'b0;
      leave     = 1'b0;
      issue     = 1'b0;
      consume   = 1'b0;
      finish    = 1'b0;
      tick_miss = 1'b0;
      unique case (play_state)
         IDLE: if (play && !play_q) begin
            start     = 1'b1;
            play_next = RUN;
         end
         RUN: if (!play) begin
            leave     = 1'b1;
            play_next = IDLE;
         end else if (sample_tick) begin
            if (cur_valid) begin
               consume = 1'b1;
               if (lane_end && cur_last && !loop) begin
                  finish    = 1'b1;
                  leave     = 1'b1;
                  play_next = IDLE;
               end
            end else begin
               tick_miss = 1'b1;
            end
         end
         default: play_next = IDLE;
      endcase
      // data landing after a stop or restart belongs to a dead session
      load = returned && (play_state == RUN) && !stale && !leave;
      unique case (bus_state)
         B_IDLE: if ((play_state == RUN) && !leave && !stale &&
                     (!cur_valid || !pre_valid) &&
                     (!fetch_stop || loop)) begin
            issue    = 1'b1;
            bus_next = B_REQ;
         end
         B_REQ:   if (!flash_mem_waitrequest) bus_next = B_WAIT;
         B_WAIT:  if (flash_mem_readdatavalid) bus_next = B_IDLE;
         default: bus_next = B_IDLE;
      endcase
   end

   always_ff @(posedge fetch_clock) begin
      if (reset) begin
         play_state        <= IDLE;
         bus_state         <= B_IDLE;
         play_q            <= 1'b0;
         dir               <= 1'b0;
         stale             <= 1'b0;
         fetch_stop        <= 1'b0;
         fetch_addr        <= CLIP_FIRST;
         flash_mem_address <= CLIP_FIRST;
         cur_data          <= '0;
         pre_data          <= '0;
         cur_valid         <= 1'b0;
         pre_valid         <= 1'b0;
         cur_last          <= 1'b0;
         pre_last          <= 1'b0;
         lane              <= '0;
         audio_out         <= '0;
         audio_valid       <= 1'b0;
         done              <= 1'b0;
         underrun          <= 1'b0;
      end else begin
         play_state  <= play_next;
         bus_state   <= bus_next;
         play_q      <= play;
         audio_valid <= 1'b0;
         done        <= finish;
         underrun    <= tick_miss;
         if (returned) stale <= 1'b0;
         if ((start || leave) && bus_state != B_IDLE && !returned)
            stale <= 1'b1;
         if (issue) flash_mem_address <= fetch_addr;
         if (start) begin
            dir        <= reverse;
            fetch_addr <= reverse ? CLIP_LAST : CLIP_FIRST;
            fetch_stop <= 1'b0;
            cur_valid  <= 1'b0;
            pre_valid  <= 1'b0;
         end
         if (consume) begin
            audio_out   <= lane_word[SAMPLE_W-1:0];
            audio_valid <= 1'b1;
            if (lane_end) begin
               cur_data  <= pre_data;
               cur_valid <= pre_valid;
               cur_last  <= pre_last;
               pre_valid <= 1'b0;
               lane      <= lane_first;
            end else begin
               lane <= dir ? lane - 1'b1 : lane + 1'b1;
            end
         end
         if (load) begin
            if (!cur_valid || (consume && lane_end && !pre_valid)) begin
               cur_data  <= flash_mem_readdata;
               cur_valid <= 1'b1;
               cur_last  <= fetch_at_end;
               lane      <= lane_first;
            end else begin
               pre_data  <= flash_mem_readdata;
               pre_valid <= 1'b1;
               pre_last  <= fetch_at_end;
            end
            if (fetch_at_end) begin
               fetch_addr <= dir ? CLIP_LAST : CLIP_FIRST;
               fetch_stop <= !loop;
            end else begin
               fetch_addr <= dir ? fetch_addr - 1'b1 : fetch_addr + 1'b1;
               fetch_stop <= 1'b0;
            end
         end
         if (leave) begin
            cur_valid <= 1'b0;
            pre_valid <= 1'b0;
         end
      end
   end
endmodule
